// File: rtl/alu_result_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage_if
// Description : Bus between the control unit / ALU and the ALU result stage.
//               The flag outputs exist only when ALU_RESULT_FLAGS_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_result_stage_if;
    logic        start;
    logic [3:0]  op_in;
    logic        hilo_wr_in;
    logic        ack;
    logic [31:0] c_hi;
    logic [31:0] c_lo;
    logic [3:0]  alu_sel;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
`ifdef ALU_RESULT_FLAGS_EN
    logic        z_zero;
    logic        z_neg;

    modport master (
        output start, op_in, hilo_wr_in, ack, c_hi, c_lo,
        input  alu_sel, busy, done, err, z_hi, z_lo, hi_q, lo_q, z_zero, z_neg
    );
    modport slave (
        input  start, op_in, hilo_wr_in, ack, c_hi, c_lo,
        output alu_sel, busy, done, err, z_hi, z_lo, hi_q, lo_q, z_zero, z_neg
    );
`else
    modport master (
        output start, op_in, hilo_wr_in, ack, c_hi, c_lo,
        input  alu_sel, busy, done, err, z_hi, z_lo, hi_q, lo_q
    );
    modport slave (
        input  start, op_in, hilo_wr_in, ack, c_hi, c_lo,
        output alu_sel, busy, done, err, z_hi, z_lo, hi_q, lo_q
    );
`endif
endinterface
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage
// Description : Sequencer and result register behind the combinational ALU.
//               Holds the op select steady, waits a per-op settle count,
//               captures the 64-bit result into Z and optionally HI/LO, then
//               handshakes completion. Optional macro ALU_RESULT_FLAGS_EN
//               adds registered zero/negative flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
    parameter int unsigned ADD_WAIT = 2,
    parameter int unsigned SUB_WAIT = 2,
    parameter int unsigned MUL_WAIT = 8,
    parameter int unsigned DIV_WAIT = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  wire logic          clk,
    input  wire logic          clr,
    alu_result_stage_if.slave  bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [3:0] c_OP_ADD = 4'b1000;
    localparam logic [3:0] c_OP_SUB = 4'b0100;
    localparam logic [3:0] c_OP_MUL = 4'b0010;
    localparam logic [3:0] c_OP_DIV = 4'b0001;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hilo;
    logic [3:0]       r_alu_sel;
    logic             r_err;
    logic [31:0]      r_z_hi;
    logic [31:0]      r_z_lo;
    logic [31:0]      r_hi_q;
    logic [31:0]      r_lo_q;

    logic             w_op_valid;
    logic [CNT_W-1:0] w_op_wait;
    logic             w_capture;

    // Decode the requested op into a validity flag and its settle count
    always_comb begin
        w_op_valid = 1'b1;
        w_op_wait  = '0;
        case (bus.op_in)
            c_OP_ADD: w_op_wait = CNT_W'(ADD_WAIT);
            c_OP_SUB: w_op_wait = CNT_W'(SUB_WAIT);
            c_OP_MUL: w_op_wait = CNT_W'(MUL_WAIT);
            c_OP_DIV: w_op_wait = CNT_W'(DIV_WAIT);
            default:  w_op_valid = 1'b0;
        endcase
    end

    // The ALU output has settled once the wait counter has drained
    assign w_capture = (r_state == c_ST_WAIT) && (r_cnt == '0);

    // Sequencer: accept/reject requests, count down settle time, handshake
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_hilo    <= 1'b0;
            r_alu_sel <= 4'b0000;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        if (w_op_valid) begin
                            r_alu_sel <= bus.op_in;
                            r_cnt     <= w_op_wait;
                            r_hilo    <= bus.hilo_wr_in;
                            r_state   <= c_ST_WAIT;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    // A start coinciding with ack is dropped; it must be re-issued in IDLE
                    if (bus.ack) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Result registers: Z always, HI/LO only when the request asked for it
    always_ff @(posedge clk) begin
        if (clr) begin
            r_z_hi <= '0;
            r_z_lo <= '0;
            r_hi_q <= '0;
            r_lo_q <= '0;
        end else if (w_capture) begin
            r_z_hi <= bus.c_hi;
            r_z_lo <= bus.c_lo;
            if (r_hilo) begin
                r_hi_q <= bus.c_hi;
                r_lo_q <= bus.c_lo;
            end
        end
    end

`ifdef ALU_RESULT_FLAGS_EN
    logic r_z_zero;
    logic r_z_neg;

    // Result flags; the sign of a product lives in the high word
    always_ff @(posedge clk) begin
        if (clr) begin
            r_z_zero <= 1'b0;
            r_z_neg  <= 1'b0;
        end else if (w_capture) begin
            r_z_zero <= ({bus.c_hi, bus.c_lo} == 64'd0);
            r_z_neg  <= (r_alu_sel == c_OP_MUL) ? bus.c_hi[31] : bus.c_lo[31];
        end
    end

    assign bus.z_zero = r_z_zero;
    assign bus.z_neg  = r_z_neg;
`endif

    assign bus.alu_sel = r_alu_sel;
    assign bus.busy    = (r_state == c_ST_WAIT);
    assign bus.done    = (r_state == c_ST_DONE);
    assign bus.err     = r_err;
    assign bus.z_hi    = r_z_hi;
    assign bus.z_lo    = r_z_lo;
    assign bus.hi_q    = r_hi_q;
    assign bus.lo_q    = r_lo_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_stage
// Description : Self-checking bench for alu_result_stage with a transaction
//               level reference model (settle table plus HI/LO shadow).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    alu_result_stage_if bus ();

    alu_result_stage dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;
    logic [3:0]  m_sel = '0;

    function automatic int wait_of(input logic [3:0] op);
        case (op)
            4'b1000: return 2;
            4'b0100: return 2;
            4'b0010: return 8;
            4'b0001: return 16;
            default: return -1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        tick();
        n_total++;
        if ({bus.alu_sel, bus.busy, bus.done, bus.err, bus.z_hi, bus.z_lo, bus.hi_q, bus.lo_q} !== '0)
            $display("FAIL reset_outputs: got sel=%b busy=%b done=%b err=%b z=%h_%h hilo=%h_%h required all 0",
                     bus.alu_sel, bus.busy, bus.done, bus.err, bus.z_hi, bus.z_lo, bus.hi_q, bus.lo_q);
        else n_pass++;
`ifdef ALU_RESULT_FLAGS_EN
        n_total++;
        if ({bus.z_zero, bus.z_neg} !== 2'b00)
            $display("FAIL reset_flags: got %b required 00", {bus.z_zero, bus.z_neg});
        else n_pass++;
`endif
        for (int i = 0; i < 5; i++) begin
            bus.c_hi = $urandom;
            bus.c_lo = $urandom;
            tick();
        end
        n_total++;
        if ({bus.z_hi, bus.z_lo, bus.busy} !== '0)
            $display("FAIL idle_no_capture: got z=%h_%h busy=%b required 0", bus.z_hi, bus.z_lo, bus.busy);
        else n_pass++;
    endtask

    task automatic test_add();
        int cyc;
        bus.c_hi = 32'h0; bus.c_lo = 32'h5;
        bus.start = 1'b1; bus.op_in = 4'b1000; bus.hilo_wr_in = 1'b0;
        tick();
        bus.start = 1'b0;
        m_sel = 4'b1000;
        n_total++;
        if (bus.alu_sel !== 4'b1000 || bus.busy !== 1'b1)
            $display("FAIL add_launch: got sel=%b busy=%b required 1000/1", bus.alu_sel, bus.busy);
        else n_pass++;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        n_total++;
        if (cyc !== 3) $display("FAIL add_latency: got %0d required 3", cyc);
        else n_pass++;
        n_total++;
        if (bus.z_hi !== 32'h0 || bus.z_lo !== 32'h5 || bus.busy !== 1'b0 || bus.hi_q !== m_hi || bus.lo_q !== m_lo)
            $display("FAIL add_result: got z=%h_%h busy=%b hilo=%h_%h required 0_5 busy 0 hilo %h_%h",
                     bus.z_hi, bus.z_lo, bus.busy, bus.hi_q, bus.lo_q, m_hi, m_lo);
        else n_pass++;
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        n_total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL add_ack: got done=%b busy=%b required 0/0", bus.done, bus.busy);
        else n_pass++;
    endtask

    task automatic test_mul_hilo();
        int cyc;
        bus.c_hi = 32'h1; bus.c_lo = 32'h8000_0000;
        bus.start = 1'b1; bus.op_in = 4'b0010; bus.hilo_wr_in = 1'b1;
        tick();
        bus.start = 1'b0; bus.hilo_wr_in = 1'b0;
        m_sel = 4'b0010;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        n_total++;
        if (cyc !== 9) $display("FAIL mul_latency: got %0d required 9", cyc);
        else n_pass++;
        m_hi = 32'h1; m_lo = 32'h8000_0000;
        n_total++;
        if (bus.z_hi !== 32'h1 || bus.hi_q !== 32'h1 || bus.lo_q !== 32'h8000_0000 || bus.z_lo !== 32'h8000_0000)
            $display("FAIL mul_hilo: got z=%h_%h hilo=%h_%h required 00000001_80000000 both",
                     bus.z_hi, bus.z_lo, bus.hi_q, bus.lo_q);
        else n_pass++;
`ifdef ALU_RESULT_FLAGS_EN
        n_total++;
        if ({bus.z_zero, bus.z_neg} !== 2'b00)
            $display("FAIL mul_flags: got %b required 00", {bus.z_zero, bus.z_neg});
        else n_pass++;
`endif
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    endtask

    task automatic test_invalid();
        int cyc;
        bus.start = 1'b1; bus.op_in = 4'b0110;
        tick();
        bus.start = 1'b0;
        n_total++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.alu_sel !== m_sel)
            $display("FAIL invalid_err: got err=%b busy=%b sel=%b required 1/0/%b", bus.err, bus.busy, bus.alu_sel, m_sel);
        else n_pass++;
        tick();
        n_total++;
        if (bus.err !== 1'b0) $display("FAIL invalid_pulse: got err=%b required 0", bus.err);
        else n_pass++;
        bus.start = 1'b1; bus.op_in = 4'b0000;
        tick();
        bus.start = 1'b0;
        n_total++;
        if (bus.err !== 1'b1 || bus.alu_sel !== m_sel)
            $display("FAIL invalid_zero_op: got err=%b sel=%b required 1/%b", bus.err, bus.alu_sel, m_sel);
        else n_pass++;
        bus.c_hi = 32'hFFFF_FFFF; bus.c_lo = 32'h1234_5678;
        bus.start = 1'b1; bus.op_in = 4'b0100; bus.hilo_wr_in = 1'b0;
        tick();
        bus.start = 1'b0;
        m_sel = 4'b0100;
        n_total++;
        if (bus.busy !== 1'b1 || bus.alu_sel !== 4'b0100 || bus.err !== 1'b0)
            $display("FAIL invalid_recover: got busy=%b sel=%b err=%b required 1/0100/0", bus.busy, bus.alu_sel, bus.err);
        else n_pass++;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        n_total++;
        if (cyc !== 3 || bus.z_lo !== 32'h1234_5678 || bus.hi_q !== m_hi)
            $display("FAIL sub_result: got cyc=%0d z_lo=%h hi_q=%h required 3/12345678/%h", cyc, bus.z_lo, bus.hi_q, m_hi);
        else n_pass++;
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    endtask

    task automatic test_abort();
        bus.c_hi = $urandom; bus.c_lo = $urandom;
        bus.start = 1'b1; bus.op_in = 4'b0001; bus.hilo_wr_in = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_hi = '0; m_lo = '0; m_sel = '0;
        n_total++;
        if ({bus.alu_sel, bus.busy, bus.done, bus.err, bus.z_hi, bus.z_lo, bus.hi_q, bus.lo_q} !== '0)
            $display("FAIL abort_clear: got sel=%b busy=%b done=%b z=%h_%h hilo=%h_%h required all 0",
                     bus.alu_sel, bus.busy, bus.done, bus.z_hi, bus.z_lo, bus.hi_q, bus.lo_q);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            bus.c_lo = $urandom;
            tick();
        end
        n_total++;
        if (bus.z_lo !== 32'h0 || bus.lo_q !== 32'h0 || bus.done !== 1'b0)
            $display("FAIL abort_no_capture: got z_lo=%h lo_q=%h done=%b required 0", bus.z_lo, bus.lo_q, bus.done);
        else n_pass++;
    endtask

    task automatic test_done_hold();
        int cyc;
        bus.c_hi = 32'hA5A5_0000; bus.c_lo = 32'h0000_5A5A;
        bus.start = 1'b1; bus.op_in = 4'b1000; bus.hilo_wr_in = 1'b0;
        tick();
        bus.start = 1'b0;
        m_sel = 4'b1000;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        n_total++;
        if (cyc !== 3) $display("FAIL hold_latency: got %0d required 3", cyc);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            bus.start = i[0];
            bus.op_in = 4'b0001;
            bus.c_hi = $urandom; bus.c_lo = $urandom;
            tick();
            n_total++;
            if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.alu_sel !== m_sel ||
                bus.z_hi !== 32'hA5A5_0000 || bus.z_lo !== 32'h0000_5A5A)
                $display("FAIL done_hold[%0d]: got done=%b busy=%b err=%b sel=%b z=%h_%h required 1/0/0/%b a5a50000_00005a5a",
                         i, bus.done, bus.busy, bus.err, bus.alu_sel, bus.z_hi, bus.z_lo, m_sel);
            else n_pass++;
        end
        bus.start = 1'b1; bus.op_in = 4'b1000; bus.ack = 1'b1;
        tick();
        bus.start = 1'b0; bus.ack = 1'b0;
        n_total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL ack_start: got done=%b busy=%b required 0/0", bus.done, bus.busy);
        else n_pass++;
        tick();
        n_total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL ack_start_ignored: got busy=%b done=%b required 0/0", bus.busy, bus.done);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0]  ops [5];
        logic [3:0]  bad [5];
        logic [3:0]  op;
        logic [31:0] exp_hi, exp_lo;
        logic        hilo, zero;
        int          idx, cyc, w;
        ops[0] = 4'b1000; ops[1] = 4'b0100; ops[2] = 4'b0010; ops[3] = 4'b0001; ops[4] = 4'b0000;
        bad[0] = 4'b0000; bad[1] = 4'b0110; bad[2] = 4'b1111; bad[3] = 4'b0011; bad[4] = 4'b1010;
        for (int it = 0; it < 25; it++) begin
            idx  = $urandom_range(0, 4);
            op   = (idx == 4) ? bad[$urandom_range(0, 4)] : ops[idx];
            hilo = 1'($urandom_range(0, 1));
            zero = ($urandom_range(0, 5) == 0);
            bus.start = 1'b1; bus.op_in = op; bus.hilo_wr_in = hilo;
            tick();
            bus.start = 1'b0; bus.hilo_wr_in = 1'($urandom_range(0, 1));
            w = wait_of(op);
            if (w < 0) begin
                n_total++;
                if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.alu_sel !== m_sel)
                    $display("FAIL rnd_invalid[%0d]: got err=%b busy=%b sel=%b required 1/0/%b", it, bus.err, bus.busy, bus.alu_sel, m_sel);
                else n_pass++;
                tick();
                continue;
            end
            m_sel = op;
            n_total++;
            if (bus.busy !== 1'b1 || bus.alu_sel !== op || bus.err !== 1'b0)
                $display("FAIL rnd_launch[%0d]: got busy=%b sel=%b err=%b required 1/%b/0", it, bus.busy, bus.alu_sel, bus.err, op);
            else n_pass++;
            cyc = 0;
            exp_hi = '0; exp_lo = '0;
            while (bus.done !== 1'b1 && cyc < 40) begin
                exp_hi = zero ? 32'h0 : 32'($urandom);
                exp_lo = zero ? 32'h0 : 32'($urandom);
                bus.c_hi = exp_hi; bus.c_lo = exp_lo;
                bus.ack = 1'($urandom_range(0, 1));
                tick();
                cyc++;
            end
            bus.ack = 1'b0;
            if (hilo) begin m_hi = exp_hi; m_lo = exp_lo; end
            n_total++;
            if (cyc !== w + 1 || bus.busy !== 1'b0)
                $display("FAIL rnd_latency[%0d]: got cyc=%0d busy=%b required %0d/0", it, cyc, bus.busy, w + 1);
            else n_pass++;
            n_total++;
            if (bus.z_hi !== exp_hi || bus.z_lo !== exp_lo || bus.hi_q !== m_hi || bus.lo_q !== m_lo)
                $display("FAIL rnd_result[%0d]: got z=%h_%h hilo=%h_%h required z=%h_%h hilo=%h_%h",
                         it, bus.z_hi, bus.z_lo, bus.hi_q, bus.lo_q, exp_hi, exp_lo, m_hi, m_lo);
            else n_pass++;
`ifdef ALU_RESULT_FLAGS_EN
            n_total++;
            if (bus.z_zero !== ((exp_hi == 0) && (exp_lo == 0)) ||
                bus.z_neg !== ((op == 4'b0010) ? exp_hi[31] : exp_lo[31]))
                $display("FAIL rnd_flags[%0d]: got zero=%b neg=%b for op %b c=%h_%h", it, bus.z_zero, bus.z_neg, op, exp_hi, exp_lo);
            else n_pass++;
`endif
            repeat ($urandom_range(0, 3)) begin
                bus.c_hi = $urandom; bus.c_lo = $urandom;
                tick();
            end
            n_total++;
            if (bus.done !== 1'b1 || bus.z_hi !== exp_hi || bus.z_lo !== exp_lo)
                $display("FAIL rnd_hold[%0d]: got done=%b z=%h_%h required 1 %h_%h", it, bus.done, bus.z_hi, bus.z_lo, exp_hi, exp_lo);
            else n_pass++;
            bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        end
    endtask

    initial begin
        clr = 1'b1;
        bus.start = 1'b0; bus.op_in = 4'b0000; bus.hilo_wr_in = 1'b0; bus.ack = 1'b0;
        bus.c_hi = '0; bus.c_lo = '0;
        test_reset();
        test_add();
        test_mul_hilo();
        test_invalid();
        test_abort();
        test_done_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
